// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage <-> HI/LO sequencer bundle: command inputs, current HI/LO,
// and the write port / pipeline control returned by the sequencer.
interface hilo_muldiv_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             flush;
  logic [WIDTH-1:0] hi_cur;
  logic [WIDTH-1:0] lo_cur;
  logic             hilo_we;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             stall_o;
  logic             busy;
  logic             div_zero;

  modport master (
    output start, op, opa, opb, flush, hi_cur, lo_cur,
    input  hilo_we, hi_o, lo_o, stall_o, busy, div_zero
  );

  modport slave (
    input  start, op, opa, opb, flush, hi_cur, lo_cur,
    output hilo_we, hi_o, lo_o, stall_o, busy, div_zero
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer: one-bit-per-cycle shift-add multiply and restoring divide,
// plus MTHI/MTLO moves, driving the HI/LO write port and pipeline stall.
module hilo_muldiv_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          DIV0_WRITE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  hilo_muldiv_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t state, state_nx;

  // acc holds {hi,lo} of the product, or {rem,quot} while dividing.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      count;
  logic               neg_q;
  logic               neg_r;
  logic               is_div;
  logic               mt_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               cmd_mul;
  logic               cmd_div;
  logic               cmd_mt;
  logic               opb_zero;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] wd;
  logic               we;

  always_comb begin
    cmd_mul   = bus.start & ~bus.flush & (bus.op[2:1] == 2'b00);
    cmd_div   = bus.start & ~bus.flush & (bus.op[2:1] == 2'b01);
    cmd_mt    = bus.start & ~bus.flush & (bus.op[2:1] == 2'b10);
    opb_zero  = (bus.opb == '0);
    a_neg     = ~bus.op[0] & bus.opa[WIDTH-1];
    b_neg     = ~bus.op[0] & bus.opb[WIDTH-1];
    a_mag     = a_neg ? -bus.opa : bus.opa;
    b_mag     = b_neg ? -bus.opb : bus.opb;
    last_iter = (count == CW'(WIDTH - 1));
  end

  // One iteration of each algorithm; the remainder is shifted before the trial subtract.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd & {WIDTH{acc[0]}}};
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, opnd};
    div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};
  end

  // MTHI/MTLO and the divide-by-zero write are staged in acc with no sign fix,
  // so every write takes the same result path.
  always_comb begin
    prod     = neg_q ? -acc : acc;
    quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    wd       = is_div ? {rem_fix, quot_fix} : prod;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (cmd_mul) begin
          state_nx = S_MUL;
        end else if (cmd_div) begin
          if (!opb_zero)      state_nx = S_DIV;
          else if (DIV0_WRITE) state_nx = S_DONE;
        end
      end
      S_MUL: begin
        if (bus.flush)      state_nx = S_IDLE;
        else if (last_iter) state_nx = S_DONE;
      end
      S_DIV: begin
        if (bus.flush)      state_nx = S_IDLE;
        else if (last_iter) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      opnd   <= '0;
      count  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      mt_q   <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      mt_q <= 1'b0;
      dz_q <= 1'b0;
      if (we) begin
        hi_q <= wd[2*WIDTH-1:WIDTH];
        lo_q <= wd[WIDTH-1:0];
      end
      case (state)
        S_IDLE: begin
          if (cmd_mul) begin
            acc    <= {{WIDTH{1'b0}}, b_mag};
            opnd   <= a_mag;
            count  <= '0;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
          end else if (cmd_div) begin
            dz_q   <= opb_zero;
            count  <= '0;
            is_div <= 1'b1;
            if (opb_zero) begin
              acc   <= {bus.opa, {WIDTH{1'b1}}};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              acc   <= {{WIDTH{1'b0}}, a_mag};
              opnd  <= b_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end else if (cmd_mt) begin
            mt_q   <= 1'b1;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= bus.op[0] ? {bus.hi_cur, bus.opa} : {bus.opa, bus.lo_cur};
          end
        end
        S_MUL: begin
          acc   <= {mul_sum, acc[WIDTH-1:1]};
          count <= count + CW'(1);
        end
        S_DIV: begin
          acc   <= div_next;
          count <= count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    we           = ~rst & (mt_q | ((state == S_DONE) & ~bus.flush));
    bus.hilo_we  = we;
    bus.hi_o     = we ? wd[2*WIDTH-1:WIDTH] : hi_q;
    bus.lo_o     = we ? wd[WIDTH-1:0] : lo_q;
    bus.stall_o  = ((state == S_IDLE) & bus.start & ~bus.op[2] & ~(bus.op[1] & opb_zero))
                 | (state == S_MUL) | (state == S_DIV);
    bus.busy     = (state != S_IDLE);
    bus.div_zero = dz_q;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Sequencer for the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the EX stage.
- Runs iterative shift-add multiply or restoring divide, one bit per cycle.
- Drives the HI/LO write port (we, hi_i, lo_i) and stalls the pipeline until the result is committed.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits; only 32 is verified.
DIV0_WRITE, 0, 0: divide-by-zero leaves HI/LO unchanged; 1: writes HI=dividend, LO=all ones.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  command valid from EX; sampled only in IDLE.
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
opa  in  WIDTH  rs value (multiplicand, dividend, or MTHI/MTLO data).
opb  in  WIDTH  rt value (multiplier or divisor).
flush  in  1  cancel the in-flight command (exception/branch squash).
hi_cur  in  WIDTH  current HI register value.
lo_cur  in  WIDTH  current LO register value.
hilo_we  out  1  HI/LO write enable, one-cycle pulse.
hi_o  out  WIDTH  HI write data.
lo_o  out  WIDTH  LO write data.
stall_o  out  1  holds the pipeline while a mul/div is in progress.
busy  out  1  state != IDLE.
div_zero  out  1  one-cycle pulse when a DIV/DIVU has divisor 0.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; hilo_we, stall_o, busy, div_zero = 0; hi_o, lo_o, all internal registers = 0. Reset mid-operation aborts with no write.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start with op 00x: latch |opa|, |opb| (magnitudes for signed MULT; raw for MULTU) and the result sign; clear accumulator and count; go to MUL.
  - start with op 01x: if opb==0, pulse div_zero next cycle; write only if DIV0_WRITE=1 (via DONE); otherwise stay in IDLE. If opb!=0, latch magnitudes (DIV) or raw values (DIVU), quotient sign = sign(opa) XOR sign(opb), remainder sign = sign(opa); go to DIV.
  - start with op 100 (MTHI): next cycle hilo_we=1, hi_o=opa, lo_o=lo_cur as sampled at start.
  - start with op 101 (MTLO): next cycle hilo_we=1, hi_o=hi_cur, lo_o=opa.
  - start with op 11x: ignored.
  - MTHI/MTLO do not stall.
- MUL: each cycle, if multiplier LSB=1 add multiplicand to the upper half of the 2*WIDTH accumulator with carry; shift right 1; count++. After WIDTH iterations go to DONE.
- DIV: restoring divide. Each cycle shift {rem,quot} left 1, trial-subtract the divisor, keep the result and set the quotient bit when non-negative; count++. After WIDTH iterations go to DONE.
- DONE (one cycle), then IDLE:
  - hilo_we=1.
  - MUL: {hi_o,lo_o} = product, two's-complement negated if the sign flag is set.
  - DIV: lo_o = quotient, hi_o = remainder, each sign-corrected.
- Latency: start accepted at edge 0; iterations at edges 1..WIDTH; DONE at edge WIDTH+1. For WIDTH=32, hilo_we is high in cycle 33.
- stall_o = (state==IDLE & start & op[2]==0 & !(DIV-type & opb==0)) | state==MUL | state==DIV. stall_o is 0 in DONE, so the dependent instruction advances the same cycle HI/LO is written.
- start while busy: ignored (upstream is stalled).
- flush in MUL/DIV/DONE: next state IDLE, hilo_we suppressed in that cycle, stall_o deasserts next cycle. flush in IDLE with start: command dropped.
- Edge cases: MULT 0x80000000*0x80000000 gives 0x40000000_00000000. DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0 (wrap, no trap).
- hi_o/lo_o hold their last value when hilo_we=0.

Test Plan:
- MULT opa=0xFFFFFFFD (-3), opb=7 -> cycle 33: hilo_we=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB; stall_o high cycles 0-32, low in 33.
- DIVU opa=100, opb=7 -> cycle 33: lo_o=14, hi_o=2. DIV opa=0xFFFFFFF9 (-7), opb=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIV opb=0, DIV0_WRITE=0 -> div_zero pulse in cycle 1, no hilo_we, stall_o never high. With DIV0_WRITE=1 and opa=5 -> cycle 1: hi_o=5, lo_o=0xFFFFFFFF.
- MTHI opa=0x12345678, lo_cur=0x0000AAAA -> next cycle hilo_we=1, hi_o=0x12345678, lo_o=0x0000AAAA; stall_o stays 0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF with flush at cycle 10 -> no hilo_we, busy=0 from cycle 11; a new DIVU 9/3 issued in cycle 11 completes with lo_o=3, hi_o=0.
- rst asserted at cycle 20 of a DIV -> all outputs 0 next cycle, no write; start accepted in the first cycle after rst drops.
